// File: rtl/reg_slv_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : reg_slv_pkg
//  Description : Shared types and constants for the register slave
//                controller: the controller state encoding and the width of
//                the downstream wait (timeout) counter.
//  Revision    : 1.0 - initial release
// ============================================================================
package reg_slv_pkg;

    // Width of the wait counter; TIMEOUT values up to 65535 fit.
    localparam int TMO_CNT_W = 16;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_DECODE   = 3'd1,
        ST_REG_ACC  = 3'd2,
        ST_EXT_WAIT = 3'd3,
        ST_FWD_WAIT = 3'd4,
        ST_RESP     = 3'd5
    } state_t;

endpackage
`default_nettype wire

// File: rtl/reg_slv_onehot_mux.sv
`default_nettype none
// ============================================================================
//  Module      : reg_slv_onehot_mux
//  Description : AND-OR multiplexer picking one WIDTH-bit slice out of a
//                flattened CNT-slice bus using a one-hot select. An all-zero
//                select yields zero.
//  Revision    : 1.0 - initial release
//  Ports       : sel   in  CNT          one-hot slice select
//                din   in  CNT*WIDTH    flattened input slices (slice 0 LSB)
//                dout  out WIDTH        selected slice
// ============================================================================
module reg_slv_onehot_mux #(
    parameter int WIDTH = 32,
    parameter int CNT   = 2
) (
    input  logic [CNT-1:0]       sel,
    input  logic [CNT*WIDTH-1:0] din,
    output logic [WIDTH-1:0]     dout
);

    logic [CNT*WIDTH-1:0] w_masked;

    genvar gi;
    generate
        for (gi = 0; gi < CNT; gi++) begin : g_slice
            assign w_masked[gi*WIDTH +: WIDTH] = din[gi*WIDTH +: WIDTH] & {WIDTH{sel[gi]}};
        end
    endgenerate

    always_comb begin
        dout = '0;
        for (int i = 0; i < CNT; i++) begin
            dout = dout | w_masked[i*WIDTH +: WIDTH];
        end
    end

endmodule
`default_nettype wire

// File: rtl/reg_slv_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : reg_slv_ctrl
//  Description : Single-outstanding register slave controller. A request is
//                captured, decoded to an internal register (exact match), an
//                external memory channel (base/mask match) or the forward
//                port, carried out, and answered with a one-cycle ack_vld.
//                Downstream waits are bounded by TIMEOUT cycles.
//  Revision    : 1.0 - initial release
//  Ports       : clk, rstn (async, active-low)
//                req_vld/wr_en/rd_en/addr/wr_data   - master request
//                ack_vld/rd_data/err                - master response
//                reg_sel/reg_wr/reg_rd/reg_wr_data/reg_rd_data
//                                                   - internal register port
//                ext_req_vld/ext_wr_en/ext_addr/ext_wr_data/ext_ack_vld/
//                ext_rd_data                        - external channels
//                fwd_req_vld/fwd_wr_en/fwd_addr/fwd_wr_data/fwd_ack_vld/
//                fwd_rd_data                        - forward port
// ============================================================================
module reg_slv_ctrl
    import reg_slv_pkg::*;
#(
    parameter int                          ADDR_WIDTH = 64,
    parameter int                          DATA_WIDTH = 32,
    parameter int                          N_REG      = 4,
    parameter int                          N_EXT      = 2,
    parameter logic [N_REG*ADDR_WIDTH-1:0] REG_ADDR   = {ADDR_WIDTH'(32'hC), ADDR_WIDTH'(32'h8),
                                                         ADDR_WIDTH'(32'h4), ADDR_WIDTH'(32'h0)},
    parameter logic [N_EXT*ADDR_WIDTH-1:0] EXT_BASE   = {ADDR_WIDTH'(32'h200), ADDR_WIDTH'(32'h100)},
    parameter logic [N_EXT*ADDR_WIDTH-1:0] EXT_MASK   = {ADDR_WIDTH'(32'hFF), ADDR_WIDTH'(32'hFF)},
    parameter logic                        FWD_EN     = 1'b1,
    parameter int                          TIMEOUT    = 255
) (
    input  logic                        clk,
    input  logic                        rstn,
    input  logic                        req_vld,
    input  logic                        wr_en,
    input  logic                        rd_en,
    input  logic [ADDR_WIDTH-1:0]       addr,
    input  logic [DATA_WIDTH-1:0]       wr_data,
    output logic                        ack_vld,
    output logic [DATA_WIDTH-1:0]       rd_data,
    output logic                        err,
    output logic [N_REG-1:0]            reg_sel,
    output logic                        reg_wr,
    output logic                        reg_rd,
    output logic [DATA_WIDTH-1:0]       reg_wr_data,
    input  logic [N_REG*DATA_WIDTH-1:0] reg_rd_data,
    output logic [N_EXT-1:0]            ext_req_vld,
    output logic                        ext_wr_en,
    output logic [ADDR_WIDTH-1:0]       ext_addr,
    output logic [DATA_WIDTH-1:0]       ext_wr_data,
    input  logic [N_EXT-1:0]            ext_ack_vld,
    input  logic [N_EXT*DATA_WIDTH-1:0] ext_rd_data,
    output logic                        fwd_req_vld,
    output logic                        fwd_wr_en,
    output logic [ADDR_WIDTH-1:0]       fwd_addr,
    output logic [DATA_WIDTH-1:0]       fwd_wr_data,
    input  logic                        fwd_ack_vld,
    input  logic [DATA_WIDTH-1:0]       fwd_rd_data
);

    // Counter value on the last permitted wait cycle.
    localparam logic [TMO_CNT_W-1:0] C_TMO_LAST = TMO_CNT_W'(TIMEOUT - 1);

    state_t                  r_state;
    state_t                  w_state_nxt;

    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [DATA_WIDTH-1:0]   r_wdata;
    logic                    r_wr;
    logic [N_REG-1:0]        r_reg_sel;
    logic [N_EXT-1:0]        r_ext_sel;
    logic [TMO_CNT_W-1:0]    r_cnt;
    logic [DATA_WIDTH-1:0]   r_rd_data;
    logic                    r_err;

    logic [N_REG-1:0]        w_reg_hit;
    logic [N_EXT-1:0]        w_ext_hit;
    logic                    w_reg_any;
    logic                    w_ext_any;
    logic [DATA_WIDTH-1:0]   w_reg_mux;
    logic [DATA_WIDTH-1:0]   w_ext_mux;
    logic                    w_ext_ack;
    logic                    w_tmo;

    logic                    w_accept;
    logic                    w_cnt_clr;
    logic                    w_cnt_inc;
    logic                    w_resp_ld;
    logic                    w_resp_err;
    logic [DATA_WIDTH-1:0]   w_resp_data;

    logic                    w_in_reg;
    logic                    w_in_ext;
    logic                    w_in_fwd;

    // ------------------------------------------------------------------
    // Address decode from the captured address. Iterating from the top
    // index down lets the lowest matching index overwrite any higher one.
    // ------------------------------------------------------------------
    always_comb begin
        w_reg_hit = '0;
        for (int i = N_REG - 1; i >= 0; i--) begin
            if (r_addr == REG_ADDR[i*ADDR_WIDTH +: ADDR_WIDTH]) begin
                w_reg_hit    = '0;
                w_reg_hit[i] = 1'b1;
            end
        end
    end

    always_comb begin
        w_ext_hit = '0;
        for (int i = N_EXT - 1; i >= 0; i--) begin
            if ((r_addr & ~EXT_MASK[i*ADDR_WIDTH +: ADDR_WIDTH]) == EXT_BASE[i*ADDR_WIDTH +: ADDR_WIDTH]) begin
                w_ext_hit    = '0;
                w_ext_hit[i] = 1'b1;
            end
        end
    end

    assign w_reg_any = |w_reg_hit;
    assign w_ext_any = |w_ext_hit;

    // Read-data slice selection for the register and external paths.
    reg_slv_onehot_mux #(
        .WIDTH (DATA_WIDTH),
        .CNT   (N_REG)
    ) u_reg_mux (
        .sel   (r_reg_sel),
        .din   (reg_rd_data),
        .dout  (w_reg_mux)
    );

    reg_slv_onehot_mux #(
        .WIDTH (DATA_WIDTH),
        .CNT   (N_EXT)
    ) u_ext_mux (
        .sel   (r_ext_sel),
        .din   (ext_rd_data),
        .dout  (w_ext_mux)
    );

    // Only the acknowledge of the channel actually being driven counts.
    assign w_ext_ack = |(ext_ack_vld & r_ext_sel);
    assign w_tmo     = (r_cnt == C_TMO_LAST);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and datapath control
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_cnt_clr   = 1'b0;
        w_cnt_inc   = 1'b0;
        w_resp_ld   = 1'b0;
        w_resp_err  = 1'b0;
        w_resp_data = '0;

        case (r_state)
            ST_IDLE: begin
                if (req_vld && (wr_en || rd_en)) begin
                    w_accept    = 1'b1;
                    w_state_nxt = ST_DECODE;
                end
            end

            ST_DECODE: begin
                w_cnt_clr = 1'b1;
                if (w_reg_any) begin
                    w_state_nxt = ST_REG_ACC;
                end else if (w_ext_any) begin
                    w_state_nxt = ST_EXT_WAIT;
                end else if (FWD_EN) begin
                    w_state_nxt = ST_FWD_WAIT;
                end else begin
                    w_resp_ld   = 1'b1;
                    w_resp_err  = 1'b1;
                    w_state_nxt = ST_RESP;
                end
            end

            ST_REG_ACC: begin
                w_resp_ld   = 1'b1;
                w_resp_data = r_wr ? '0 : w_reg_mux;
                w_state_nxt = ST_RESP;
            end

            ST_EXT_WAIT: begin
                // An acknowledge on the final wait cycle beats the timeout.
                if (w_ext_ack) begin
                    w_resp_ld   = 1'b1;
                    w_resp_data = r_wr ? '0 : w_ext_mux;
                    w_state_nxt = ST_RESP;
                end else if (w_tmo) begin
                    w_resp_ld   = 1'b1;
                    w_resp_err  = 1'b1;
                    w_state_nxt = ST_RESP;
                end else begin
                    w_cnt_inc = 1'b1;
                end
            end

            ST_FWD_WAIT: begin
                if (fwd_ack_vld) begin
                    w_resp_ld   = 1'b1;
                    w_resp_data = r_wr ? '0 : fwd_rd_data;
                    w_state_nxt = ST_RESP;
                end else if (w_tmo) begin
                    w_resp_ld   = 1'b1;
                    w_resp_err  = 1'b1;
                    w_state_nxt = ST_RESP;
                end else begin
                    w_cnt_inc = 1'b1;
                end
            end

            ST_RESP: begin
                w_state_nxt = ST_IDLE;
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Capture, decode-result, wait-counter and response flops
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_addr    <= '0;
            r_wdata   <= '0;
            r_wr      <= 1'b0;
            r_reg_sel <= '0;
            r_ext_sel <= '0;
            r_cnt     <= '0;
            r_rd_data <= '0;
            r_err     <= 1'b0;
        end else begin
            if (w_accept) begin
                r_addr  <= addr;
                r_wdata <= wr_data;
                r_wr    <= wr_en;
            end
            if (r_state == ST_DECODE) begin
                r_reg_sel <= w_reg_hit;
                // A register hit outranks any channel hit.
                r_ext_sel <= w_reg_any ? '0 : w_ext_hit;
            end
            if (w_cnt_clr) begin
                r_cnt <= '0;
            end else if (w_cnt_inc) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (w_resp_ld) begin
                r_rd_data <= w_resp_data;
                r_err     <= w_resp_err;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs: downstream strobes are qualified by the active state so
    // they are low outside their own access phase.
    // ------------------------------------------------------------------
    assign w_in_reg = (r_state == ST_REG_ACC);
    assign w_in_ext = (r_state == ST_EXT_WAIT);
    assign w_in_fwd = (r_state == ST_FWD_WAIT);

    assign ack_vld     = (r_state == ST_RESP);
    assign rd_data     = r_rd_data;
    assign err         = ack_vld & r_err;

    assign reg_sel     = r_reg_sel & {N_REG{w_in_reg}};
    assign reg_wr      = w_in_reg & r_wr;
    assign reg_rd      = w_in_reg & ~r_wr;
    assign reg_wr_data = w_in_reg ? r_wdata : '0;

    assign ext_req_vld = r_ext_sel & {N_EXT{w_in_ext}};
    assign ext_wr_en   = w_in_ext & r_wr;
    assign ext_addr    = w_in_ext ? r_addr : '0;
    assign ext_wr_data = w_in_ext ? r_wdata : '0;

    assign fwd_req_vld = w_in_fwd;
    assign fwd_wr_en   = w_in_fwd & r_wr;
    assign fwd_addr    = w_in_fwd ? r_addr : '0;
    assign fwd_wr_data = w_in_fwd ? r_wdata : '0;

endmodule
`default_nettype wire

// File: tb/tb_reg_slv_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_reg_slv_ctrl
//  Description : Scoreboard bench for reg_slv_ctrl. Instance A uses
//                FWD_EN=1 and TIMEOUT=8; instance B uses FWD_EN=0.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_reg_slv_ctrl;

    localparam int AW = 64;
    localparam int DW = 32;
    localparam int NR = 4;
    localparam int NE = 2;

    typedef struct {
        int unsigned    cyc;
        logic [DW-1:0]  data;
        logic           err;
    } exp_t;

    logic clk  = 1'b0;
    logic rstn = 1'b0;

    // Shared read-data sources
    logic [NR*DW-1:0] reg_rd_data = {32'h0F0F0F0F, 32'hA5A5A5A5, 32'h22222222, 32'h11111111};
    logic [NE*DW-1:0] ext_rd_data = {32'h5555AAAA, 32'h0BADF00D};
    logic [DW-1:0]    fwd_rd_data = 32'h0000DEAD;

    // Instance A
    logic            req_vld = 0, wr_en = 0, rd_en = 0;
    logic [AW-1:0]   addr = '0;
    logic [DW-1:0]   wr_data = '0;
    logic            ack_vld, err, reg_wr, reg_rd, ext_wr_en, fwd_req_vld, fwd_wr_en;
    logic [DW-1:0]   rd_data, reg_wr_data, ext_wr_data, fwd_wr_data;
    logic [NR-1:0]   reg_sel;
    logic [NE-1:0]   ext_req_vld;
    logic [NE-1:0]   ext_ack_vld = '0;
    logic            fwd_ack_vld = 1'b0;
    logic [AW-1:0]   ext_addr, fwd_addr;

    // Instance B
    logic            req_vld_b = 0, wr_en_b = 0, rd_en_b = 0;
    logic [AW-1:0]   addr_b = '0;
    logic [DW-1:0]   wr_data_b = '0;
    logic            ack_vld_b, err_b, reg_wr_b, reg_rd_b, ext_wr_en_b, fwd_req_vld_b, fwd_wr_en_b;
    logic [DW-1:0]   rd_data_b, reg_wr_data_b, ext_wr_data_b, fwd_wr_data_b;
    logic [NR-1:0]   reg_sel_b;
    logic [NE-1:0]   ext_req_vld_b;
    logic [NE-1:0]   ext_ack_vld_b = '0;
    logic            fwd_ack_vld_b = 1'b0;
    logic [AW-1:0]   ext_addr_b, fwd_addr_b;

    int          checks   = 0;
    int          failures = 0;
    int unsigned cyc      = 0;
    exp_t        q[$];
    exp_t        q_b[$];

    initial forever #5 clk = ~clk;
    initial forever begin
        @(posedge clk);
        cyc = cyc + 1;
    end

    reg_slv_ctrl #(.FWD_EN(1'b1), .TIMEOUT(8)) dut (
        .clk(clk), .rstn(rstn),
        .req_vld(req_vld), .wr_en(wr_en), .rd_en(rd_en), .addr(addr), .wr_data(wr_data),
        .ack_vld(ack_vld), .rd_data(rd_data), .err(err),
        .reg_sel(reg_sel), .reg_wr(reg_wr), .reg_rd(reg_rd), .reg_wr_data(reg_wr_data),
        .reg_rd_data(reg_rd_data),
        .ext_req_vld(ext_req_vld), .ext_wr_en(ext_wr_en), .ext_addr(ext_addr),
        .ext_wr_data(ext_wr_data), .ext_ack_vld(ext_ack_vld), .ext_rd_data(ext_rd_data),
        .fwd_req_vld(fwd_req_vld), .fwd_wr_en(fwd_wr_en), .fwd_addr(fwd_addr),
        .fwd_wr_data(fwd_wr_data), .fwd_ack_vld(fwd_ack_vld), .fwd_rd_data(fwd_rd_data)
    );

    reg_slv_ctrl #(.FWD_EN(1'b0)) dut_b (
        .clk(clk), .rstn(rstn),
        .req_vld(req_vld_b), .wr_en(wr_en_b), .rd_en(rd_en_b), .addr(addr_b), .wr_data(wr_data_b),
        .ack_vld(ack_vld_b), .rd_data(rd_data_b), .err(err_b),
        .reg_sel(reg_sel_b), .reg_wr(reg_wr_b), .reg_rd(reg_rd_b), .reg_wr_data(reg_wr_data_b),
        .reg_rd_data(reg_rd_data),
        .ext_req_vld(ext_req_vld_b), .ext_wr_en(ext_wr_en_b), .ext_addr(ext_addr_b),
        .ext_wr_data(ext_wr_data_b), .ext_ack_vld(ext_ack_vld_b), .ext_rd_data(ext_rd_data),
        .fwd_req_vld(fwd_req_vld_b), .fwd_wr_en(fwd_wr_en_b), .fwd_addr(fwd_addr_b),
        .fwd_wr_data(fwd_wr_data_b), .fwd_ack_vld(fwd_ack_vld_b), .fwd_rd_data(fwd_rd_data)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            failures = failures + 1;
            $display("FAIL %s actual=%0h expected=%0h (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    // Advance to #1 after the posedge that starts cycle t.
    task automatic goto(input int unsigned t);
        while (cyc < t) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_a(input int unsigned c, input logic [DW-1:0] d, input logic e);
        exp_t x;
        x.cyc = c; x.data = d; x.err = e;
        q.push_back(x);
    endtask

    task automatic push_b(input int unsigned c, input logic [DW-1:0] d, input logic e);
        exp_t x;
        x.cyc = c; x.data = d; x.err = e;
        q_b.push_back(x);
    endtask

    // Present a one-cycle request; c returns the accepting cycle.
    task automatic issue(input logic [AW-1:0] a, input logic wr, input logic [DW-1:0] d,
                         output int unsigned c);
        req_vld = 1'b1; wr_en = wr; rd_en = ~wr; addr = a; wr_data = d;
        c = cyc;
        @(posedge clk);
        #1;
        req_vld = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
    endtask

    task automatic issue_b(input logic [AW-1:0] a, input logic wr, input logic [DW-1:0] d,
                           output int unsigned c);
        req_vld_b = 1'b1; wr_en_b = wr; rd_en_b = ~wr; addr_b = a; wr_data_b = d;
        c = cyc;
        @(posedge clk);
        #1;
        req_vld_b = 1'b0; wr_en_b = 1'b0; rd_en_b = 1'b0;
    endtask

    // Monitors: every ack_vld pops one expected response.
    initial forever begin
        exp_t e;
        @(negedge clk);
        if (ack_vld === 1'b1) begin
            if (q.size() == 0) begin
                checks   = checks + 1;
                failures = failures + 1;
                $display("FAIL unexpected_ack_a cyc=%0d rd_data=%0h err=%b", cyc, rd_data, err);
            end else begin
                e = q.pop_front();
                chk("a_ack_cycle", 64'(cyc), 64'(e.cyc));
                chk("a_rd_data", 64'(rd_data), 64'(e.data));
                chk("a_err", 64'(err), 64'(e.err));
            end
        end
    end

    initial forever begin
        exp_t e;
        @(negedge clk);
        if (ack_vld_b === 1'b1) begin
            if (q_b.size() == 0) begin
                checks   = checks + 1;
                failures = failures + 1;
                $display("FAIL unexpected_ack_b cyc=%0d rd_data=%0h err=%b", cyc, rd_data_b, err_b);
            end else begin
                e = q_b.pop_front();
                chk("b_ack_cycle", 64'(cyc), 64'(e.cyc));
                chk("b_rd_data", 64'(rd_data_b), 64'(e.data));
                chk("b_err", 64'(err_b), 64'(e.err));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned c;
        int unsigned c2;
        int          cnt;

        // Reset values
        goto(3);
        @(negedge clk);
        chk("rst_ack_vld", 64'(ack_vld), 0);
        chk("rst_err", 64'(err), 0);
        chk("rst_rd_data", 64'(rd_data), 0);
        chk("rst_reg", 64'({reg_sel, reg_wr, reg_rd}), 0);
        chk("rst_ext", 64'({ext_req_vld, ext_wr_en}), 0);
        chk("rst_ext_addr", ext_addr, 0);
        chk("rst_fwd", 64'({fwd_req_vld, fwd_wr_en}), 0);
        chk("rst_fwd_addr", fwd_addr, 0);
        goto(cyc + 1);
        rstn = 1'b1;
        goto(cyc + 2);

        // Register 2 read: one-cycle select, ack three cycles after accept
        issue(64'h8, 1'b0, '0, c);
        push_a(c + 3, 32'hA5A5A5A5, 1'b0);
        @(negedge clk);
        chk("rd2_sel_early", 64'(reg_sel), 0);
        goto(c + 2);
        @(negedge clk);
        chk("rd2_sel", 64'(reg_sel), 64'(4'b0100));
        chk("rd2_dir", 64'({reg_wr, reg_rd}), 64'(2'b01));
        goto(c + 3);
        @(negedge clk);
        chk("rd2_sel_late", 64'(reg_sel), 0);
        goto(c + 5);

        // Register 1 write
        issue(64'h4, 1'b1, 32'hCAFEBABE, c);
        push_a(c + 3, 32'h0, 1'b0);
        goto(c + 2);
        @(negedge clk);
        chk("wr1_sel", 64'(reg_sel), 64'(4'b0010));
        chk("wr1_dir", 64'({reg_wr, reg_rd}), 64'(2'b10));
        chk("wr1_data", 64'(reg_wr_data), 64'(32'hCAFEBABE));
        goto(c + 5);

        // External write to channel 0, acked on the sixth wait cycle
        issue(64'h110, 1'b1, 32'h1234, c);
        push_a(c + 8, 32'h0, 1'b0);
        goto(c + 2);
        @(negedge clk);
        chk("ext_wr_req", 64'(ext_req_vld), 64'(2'b01));
        chk("ext_wr_addr", ext_addr, 64'h110);
        chk("ext_wr_en", 64'(ext_wr_en), 1);
        chk("ext_wr_data", 64'(ext_wr_data), 64'h1234);
        goto(c + 4);
        ext_ack_vld = 2'b10;          // wrong channel, must be ignored
        goto(c + 5);
        ext_ack_vld = 2'b00;
        goto(c + 6);
        @(negedge clk);
        chk("ext_wr_hold_req", 64'(ext_req_vld), 64'(2'b01));
        chk("ext_wr_hold_addr", ext_addr, 64'h110);
        goto(c + 7);
        ext_ack_vld = 2'b01;
        goto(c + 8);
        ext_ack_vld = 2'b00;
        goto(c + 10);

        // Channel 1 read, acked on the first wait cycle
        issue(64'h2A4, 1'b0, '0, c);
        push_a(c + 3, 32'h5555AAAA, 1'b0);
        goto(c + 2);
        ext_ack_vld = 2'b10;
        goto(c + 3);
        ext_ack_vld = 2'b00;
        goto(c + 5);

        // Channel 1 read never acked: eight wait cycles then error
        issue(64'h220, 1'b0, '0, c);
        push_a(c + 10, 32'h0, 1'b1);
        cnt = 0;
        for (int k = 1; k <= 12; k++) begin
            goto(c + k);
            @(negedge clk);
            if (ext_req_vld == 2'b10) cnt = cnt + 1;
        end
        chk("tmo_req_cycles", 64'(cnt), 8);
        goto(c + 14);

        // Ack on the final wait cycle beats the timeout
        issue(64'h2A4, 1'b0, '0, c);
        push_a(c + 10, 32'h5555AAAA, 1'b0);
        goto(c + 9);
        ext_ack_vld = 2'b10;
        goto(c + 10);
        ext_ack_vld = 2'b00;
        goto(c + 12);

        // Forward read with a second request during the wait
        issue(64'h900, 1'b0, '0, c);
        push_a(c + 5, 32'h0000DEAD, 1'b0);
        goto(c + 2);
        @(negedge clk);
        chk("fwd_rd_req", 64'(fwd_req_vld), 1);
        chk("fwd_rd_addr", fwd_addr, 64'h900);
        chk("fwd_rd_wr_en", 64'(fwd_wr_en), 0);
        goto(c + 3);
        req_vld = 1'b1; rd_en = 1'b1; addr = 64'h8;
        goto(c + 4);
        req_vld = 1'b0; rd_en = 1'b0;
        fwd_ack_vld = 1'b1;
        @(negedge clk);
        chk("fwd_rd_hold_req", 64'(fwd_req_vld), 1);
        goto(c + 5);
        fwd_ack_vld = 1'b0;
        goto(c + 8);

        // Forward write, acked at once: write response returns zero data
        issue(64'h3000, 1'b1, 32'h55, c);
        push_a(c + 3, 32'h0, 1'b0);
        goto(c + 2);
        @(negedge clk);
        chk("fwd_wr_strobes", 64'({fwd_req_vld, fwd_wr_en}), 64'(2'b11));
        chk("fwd_wr_data", 64'(fwd_wr_data), 64'h55);
        chk("fwd_wr_addr", fwd_addr, 64'h3000);
        fwd_ack_vld = 1'b1;
        goto(c + 3);
        fwd_ack_vld = 1'b0;
        goto(c + 5);

        // Request strobe without a direction is not accepted
        req_vld = 1'b1; addr = 64'h0;
        goto(cyc + 1);
        req_vld = 1'b0;
        goto(cyc + 5);

        // Back-to-back: second request in the cycle after the response
        issue(64'h0, 1'b0, '0, c);
        push_a(c + 3, 32'h11111111, 1'b0);
        goto(c + 4);
        issue(64'hC, 1'b0, '0, c2);
        push_a(c2 + 3, 32'h0F0F0F0F, 1'b0);
        goto(c2 + 5);

        // Asynchronous reset during an external wait aborts without ack
        issue(64'h100, 1'b0, '0, c);
        goto(c + 3);
        rstn = 1'b0;
        @(negedge clk);
        chk("rst_mid_ack", 64'(ack_vld), 0);
        chk("rst_mid_ext_req", 64'(ext_req_vld), 0);
        chk("rst_mid_ext_addr", ext_addr, 0);
        chk("rst_mid_rd_data", 64'(rd_data), 0);
        goto(c + 5);
        rstn = 1'b1;
        goto(c + 7);
        issue(64'h8, 1'b0, '0, c2);
        push_a(c2 + 3, 32'hA5A5A5A5, 1'b0);
        goto(c2 + 5);

        // Instance B (no forward port)
        issue_b(64'h8, 1'b0, '0, c);
        push_b(c + 3, 32'hA5A5A5A5, 1'b0);
        goto(c + 5);
        issue_b(64'h900, 1'b0, '0, c);
        push_b(c + 2, 32'h0, 1'b1);
        cnt = 0;
        for (int k = 1; k <= 4; k++) begin
            goto(c + k);
            @(negedge clk);
            if (|{fwd_req_vld_b, ext_req_vld_b, reg_sel_b, reg_wr_b, reg_rd_b}) cnt = cnt + 1;
        end
        chk("nofwd_strobes", 64'(cnt), 0);
        goto(c + 6);

        chk("sb_drain_a", 64'(q.size()), 0);
        chk("sb_drain_b", 64'(q_b.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
